// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: per-stage enables, bubble clears, multi-cycle EX hold.
// Optional macro PIPE_STALL_CNT_EN adds a free-running count of cycles with the PC stalled.
module pipe_stall_ctrl #(
    parameter int MC_LAT_W    = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_use_hz,
    input  logic                ex_mc_start,
    input  logic [MC_LAT_W-1:0] ex_mc_lat,
    input  logic                mem_wait,
    input  logic                ex_redirect,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                idex_en,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                ifid_clr,
    output logic                idex_clr,
    output logic                exmem_clr,
    output logic                busy
`ifdef PIPE_STALL_CNT_EN
   ,output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    typedef enum logic {ST_RUN = 1'b0, ST_MC = 1'b1} state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_clr;
        logic idex_clr;
        logic exmem_clr;
    } ctrl_t;

    // A latency of 2 is the smallest that stalls, so the lat field must hold it.
    if (MC_LAT_W < 2 || STALL_CNT_W < 1) begin : g_bad_param
        $error("pipe_stall_ctrl: MC_LAT_W must be >= 2 and STALL_CNT_W >= 1");
    end

    state_t              r_state;
    logic [MC_LAT_W-1:0] r_cnt;

    logic  w_mc_req;
    logic  w_ex_held;
    ctrl_t w_ctrl;

    assign w_mc_req  = ex_mc_start && (ex_mc_lat >= MC_LAT_W'(2));
    assign w_ex_held = ((r_state == ST_RUN) && w_mc_req) ||
                       ((r_state == ST_MC) && (r_cnt != '0));

    // Redirect only reaches the last-but-held branches; below the hold check EX always advances.
    always_comb begin
        w_ctrl = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                   memwb_en: 1'b1, default: 1'b0};
        if (!reset_n || mem_wait) begin
            w_ctrl = '0;
        end else if (w_ex_held) begin
            w_ctrl.pc_en     = 1'b0;
            w_ctrl.ifid_en   = 1'b0;
            w_ctrl.idex_en   = 1'b0;
            w_ctrl.exmem_clr = 1'b1;
        end else if (ex_redirect) begin
            w_ctrl.ifid_clr = 1'b1;
            w_ctrl.idex_clr = 1'b1;
        end else if (load_use_hz) begin
            w_ctrl.pc_en    = 1'b0;
            w_ctrl.ifid_en  = 1'b0;
            w_ctrl.idex_clr = 1'b1;
        end
    end

    assign pc_en     = w_ctrl.pc_en;
    assign ifid_en   = w_ctrl.ifid_en;
    assign idex_en   = w_ctrl.idex_en;
    assign exmem_en  = w_ctrl.exmem_en;
    assign memwb_en  = w_ctrl.memwb_en;
    assign ifid_clr  = w_ctrl.ifid_clr;
    assign idex_clr  = w_ctrl.idex_clr;
    assign exmem_clr = w_ctrl.exmem_clr;
    assign busy      = reset_n && (r_state == ST_MC);

    // The countdown keeps running through mem_wait; only the final release waits for memory.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mc_req && !mem_wait) begin
                        r_state <= ST_MC;
                        r_cnt   <= ex_mc_lat - MC_LAT_W'(2);
                    end
                end
                ST_MC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - MC_LAT_W'(1);
                    end else if (!mem_wait) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (!w_ctrl.pc_en) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage core pipeline.
- Generates the per-stage enable and synchronous-clear controls that drive the IF/ID, ID/EX, EX/MEM and MEM/WB enable registers and the PC register.
- Sequences load-use bubbles, multi-cycle EX operations (div/FPU), data-memory wait freezes and EX-resolved redirects.

Parameters:
- MC_LAT_W, 5: width of the multi-cycle latency input and internal countdown.
- STALL_CNT_W, 32: width of the optional stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_use_hz  in  1  ID instruction depends on the load currently in EX
- ex_mc_start  in  1  EX instruction is a multi-cycle op; held while it stays in EX
- ex_mc_lat  in  MC_LAT_W  total EX occupancy in cycles for that op
- mem_wait  in  1  data memory not ready; MEM must hold
- ex_redirect  in  1  EX resolved a mispredict or jump; younger instructions are invalid
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_clr, idex_clr, exmem_clr  out  1 each  synchronous bubble insert; asserted only together with the matching en=1
- busy  out  1  high while state is MC

Behaviour:
- Reset: state RUN, cnt=0. While reset_n=0, all en=0, all clr=0 and busy=0. Reset takes effect asynchronously and aborts any MC sequence.
- FSM states: RUN and MC. busy = (state==MC).
- ex_advance: EX advances this cycle when exmem_en=1 and exmem_clr=0.
- Output priority, highest first:
  1. mem_wait=1: every en=0 and every clr=0 (full freeze). Counter behaviour is defined under Counter below.
  2. EX held, meaning (RUN and ex_mc_start and ex_mc_lat>=2) or (MC and cnt!=0): pc_en=ifid_en=idex_en=0; exmem_en=1 with exmem_clr=1; memwb_en=1.
  3. ex_redirect=1 with EX advancing: all en=1; ifid_clr=idex_clr=1. This overrides load_use_hz.
  4. load_use_hz=1: pc_en=ifid_en=0; idex_en=1 with idex_clr=1; exmem_en=memwb_en=1.
  5. Otherwise all en=1 and all clr=0.
- Transitions:
  - RUN→MC when ex_mc_start=1, ex_mc_lat>=2 and mem_wait=0. Load cnt<=ex_mc_lat-2.
  - If mem_wait=1, stay in RUN. ex_mc_start stays held, so the start is re-evaluated next cycle.
  - ex_mc_lat of 0 or 1 means no stall.
- Counter:
  - In MC, cnt decrements each cycle while cnt!=0, including during mem_wait, because the unit runs independently.
  - MC with cnt==0 and mem_wait=0: EX advances (exmem_en=1, exmem_clr=0) and the FSM returns to RUN.
  - MC with cnt==0 and mem_wait=1: remain in MC with cnt=0.
  - ex_mc_start is ignored in MC, so the same instruction is never restarted.
- Net result: the multi-cycle instruction occupies EX for exactly ex_mc_lat unfrozen-equivalent cycles (ex_mc_lat-1 bubble cycles), plus any mem_wait cycles.
- ex_redirect only takes effect in a cycle where EX advances. While EX is held or frozen, it is ignored and re-sampled.
- All outputs are combinational from state, cnt and inputs. No input-to-output registering.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [STALL_CNT_W-1:0].
  - Increments by 1 on every clock with reset_n=1 and pc_en=0; wraps to 0 on overflow.
  - Asynchronously reset to 0.
- Undefined: the port and counter are absent and there is no other behavioural difference.

Test Plan:
- Reset release, all inputs 0 → all en=1, all clr=0, busy=0 on the first cycle.
- load_use_hz=1 for one cycle → that cycle pc_en=ifid_en=0, idex_clr=1; next cycle all en=1, all clr=0.
- ex_mc_start with ex_mc_lat=4, held until advance:
  - Cycles 0–2: pc_en=ifid_en=idex_en=0, exmem_clr=1.
  - busy=1 in cycles 1–3.
  - Cycle 3: exmem_en=1, exmem_clr=0; cycle 4 is RUN.
  - Repeat with ex_mc_lat=1 → zero stall cycles.
- ex_mc_lat=3 with mem_wait=1 from cycle 1 to cycle 4:
  - cnt reaches 0, state stays MC, all en=0 during cycles 1–4.
  - Cycle 5: EX advances, return to RUN, no restart.
- ex_redirect=1 and load_use_hz=1 in the same RUN cycle → pc_en=1, ifid_clr=idex_clr=1.
- reset_n dropped mid-MC (cnt=5) → state RUN and all en=0 immediately, without waiting for a clock edge.
  - With PIPE_STALL_CNT_EN, stall_cycles=0.
  - After the lat=4 scenario without reset, stall_cycles has increased by exactly 3.
